elevator_car_plant: RTL and testbench



---
 rtl/elevator_car_plant.sv | 169 ++++++++++++++++
 tb/tb_elevator_car_plant.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_plant.sv
// Plant model of an elevator car, shaft and door operator: turns motor/door
// commands into floor sensors and door status, and latches illegal command faults.
module elevator_car_plant #(
   parameter int NUM_FLOORS   = 4,
   parameter int FLOOR_BITS   = 2,
   parameter int TRAVEL_TICKS = 16,
   parameter int DOOR_TICKS   = 8,
   parameter int START_FLOOR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  motor_up,
   input  logic                  motor_down,
   input  logic                  door_open,
   input  logic                  door_close,
   output logic [NUM_FLOORS-1:0] floor_sensors,
   output logic [FLOOR_BITS-1:0] car_floor,
   output logic                  moving,
   output logic                  door_closed,
   output logic                  door_fully_open,
   output logic [3:0]            fault_flags
);

   localparam int SUB_W  = (TRAVEL_TICKS > 2) ? $clog2(TRAVEL_TICKS) : 1;
   localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

   localparam logic [SUB_W-1:0]      SUB_MAX   = SUB_W'(TRAVEL_TICKS - 1);
   localparam logic [FLOOR_BITS-1:0] TOP_FLOOR = FLOOR_BITS'(NUM_FLOORS - 1);
   localparam logic [FLOOR_BITS-1:0] START     = FLOOR_BITS'(START_FLOOR);
   localparam logic [DOOR_W-1:0]     DOOR_MAX  = DOOR_W'(DOOR_TICKS);
   localparam logic [NUM_FLOORS-1:0] ONE_HOT1  = NUM_FLOORS'(1);

   typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_st_e;

   door_st_e              door_st_q, door_st_d;
   logic [FLOOR_BITS-1:0] floor_q, floor_d;
   logic [SUB_W-1:0]      sub_q, sub_d;
   logic [DOOR_W-1:0]     door_pos_q, door_pos_d;
   logic [NUM_FLOORS-1:0] floor_sensors_q, floor_sensors_d;
   logic                  moving_q, moving_d;
   logic                  door_closed_q, door_closed_d;
   logic                  door_fully_open_q, door_fully_open_d;
   logic [3:0]            fault_q, fault_d;

   logic                  aligned, motor_any;
   logic [DOOR_W-1:0]     door_inc, door_dec;

   always_comb begin
      floor_d   = floor_q;
      sub_d     = sub_q;
      door_st_d = door_st_q;
      door_pos_d = door_pos_q;
      fault_d   = fault_q;
      moving_d  = 1'b0;
      aligned   = (sub_q == '0);
      motor_any = motor_up | motor_down;
      door_inc  = (door_pos_q == DOOR_MAX) ? DOOR_MAX : door_pos_q + DOOR_W'(1);
      door_dec  = (door_pos_q == '0) ? '0 : door_pos_q - DOOR_W'(1);

      // Car motion: only with exactly one motor and the door fully shut.
      if (motor_up & motor_down) begin
         fault_d[0] = 1'b1;
      end else if (motor_any && door_pos_q != '0) begin
         fault_d[1] = 1'b1;
      end else if (motor_up) begin
         if (aligned && floor_q == TOP_FLOOR) begin
            fault_d[2] = 1'b1;
         end else begin
            moving_d = 1'b1;
            if (sub_q == SUB_MAX) begin
               floor_d = floor_q + FLOOR_BITS'(1);
               sub_d   = '0;
            end else begin
               sub_d = sub_q + SUB_W'(1);
            end
         end
      end else if (motor_down) begin
         if (aligned && floor_q == '0) begin
            fault_d[2] = 1'b1;
         end else begin
            moving_d = 1'b1;
            if (aligned) begin
               floor_d = floor_q - FLOOR_BITS'(1);
               sub_d   = SUB_MAX;
            end else begin
               sub_d = sub_q - SUB_W'(1);
            end
         end
      end

      // Door operator; door_open always beats door_close.
      case (door_st_q)
         CLOSED: begin
            if (door_open) begin
               if (aligned && !motor_any) begin
                  door_pos_d = door_inc;
                  door_st_d  = (door_inc == DOOR_MAX) ? OPEN : OPENING;
               end else begin
                  fault_d[3] = 1'b1;
               end
            end
         end
         OPENING: begin
            if (door_close && !door_open) begin
               door_pos_d = door_dec;
               door_st_d  = (door_dec == '0) ? CLOSED : CLOSING;
            end else begin
               door_pos_d = door_inc;
               door_st_d  = (door_inc == DOOR_MAX) ? OPEN : OPENING;
            end
         end
         OPEN: begin
            if (door_close && !door_open) begin
               door_pos_d = door_dec;
               door_st_d  = (door_dec == '0) ? CLOSED : CLOSING;
            end
         end
         CLOSING: begin
            if (door_open) begin
               door_pos_d = door_inc;
               door_st_d  = (door_inc == DOOR_MAX) ? OPEN : OPENING;
            end else begin
               door_pos_d = door_dec;
               door_st_d  = (door_dec == '0) ? CLOSED : CLOSING;
            end
         end
         default: begin
            door_st_d  = CLOSED;
            door_pos_d = '0;
         end
      endcase

      floor_sensors_d   = (sub_d == '0) ? (ONE_HOT1 << floor_d) : '0;
      door_closed_d     = (door_pos_d == '0);
      door_fully_open_d = (door_pos_d == DOOR_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         door_st_q         <= CLOSED;
         floor_q           <= START;
         sub_q             <= '0;
         door_pos_q        <= '0;
         floor_sensors_q   <= ONE_HOT1 << START;
         moving_q          <= 1'b0;
         door_closed_q     <= 1'b1;
         door_fully_open_q <= 1'b0;
         fault_q           <= '0;
      end else begin
         door_st_q         <= door_st_d;
         floor_q           <= floor_d;
         sub_q             <= sub_d;
         door_pos_q        <= door_pos_d;
         floor_sensors_q   <= floor_sensors_d;
         moving_q          <= moving_d;
         door_closed_q     <= door_closed_d;
         door_fully_open_q <= door_fully_open_d;
         fault_q           <= fault_d;
      end
   end

   assign floor_sensors   = floor_sensors_q;
   assign car_floor       = floor_q;
   assign moving          = moving_q;
   assign door_closed     = door_closed_q;
   assign door_fully_open = door_fully_open_q;
   assign fault_flags     = fault_q;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Closed-form model of car position and door travel, checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_elevator_car_plant;

   localparam int NF = 4;
   localparam int T  = 16;
   localparam int DT = 8;
   localparam int SF = 0;
   localparam int MAXPOS = (NF - 1) * T;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       motor_up = 1'b0, motor_down = 1'b0, door_open = 1'b0, door_close = 1'b0;
   logic [3:0] floor_sensors;
   logic [1:0] car_floor;
   logic       moving, door_closed, door_fully_open;
   logic [3:0] fault_flags;

   int tests = 0;
   int failed = 0;

   // Model: linear car position, door position plus travel direction.
   int         m_pos = SF * T;
   int         m_dpos = 0;
   int         m_dir = 0;
   logic       m_moving = 1'b0;
   logic [3:0] m_fault = 4'b0;

   elevator_car_plant #(
      .NUM_FLOORS(NF), .FLOOR_BITS(2), .TRAVEL_TICKS(T), .DOOR_TICKS(DT), .START_FLOOR(SF)
   ) dut (
      .clk(clk), .reset(reset),
      .motor_up(motor_up), .motor_down(motor_down),
      .door_open(door_open), .door_close(door_close),
      .floor_sensors(floor_sensors), .car_floor(car_floor), .moving(moving),
      .door_closed(door_closed), .door_fully_open(door_fully_open),
      .fault_flags(fault_flags)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      bit aligned;
      aligned  = (m_pos % T) == 0;
      m_moving = 1'b0;
      if (reset) begin
         m_pos = SF * T; m_dpos = 0; m_dir = 0; m_fault = 4'b0;
         return;
      end
      if (motor_up && motor_down) m_fault[0] = 1'b1;
      else if ((motor_up || motor_down) && m_dpos != 0) m_fault[1] = 1'b1;
      else if (motor_up) begin
         if (m_pos == MAXPOS) m_fault[2] = 1'b1;
         else begin m_pos++; m_moving = 1'b1; end
      end else if (motor_down) begin
         if (m_pos == 0) m_fault[2] = 1'b1;
         else begin m_pos--; m_moving = 1'b1; end
      end
      if (m_dpos == 0 && m_dir == 0) begin
         if (door_open) begin
            if (aligned && !motor_up && !motor_down) begin m_dpos = 1; m_dir = 1; end
            else m_fault[3] = 1'b1;
         end
      end else if (door_open) begin
         if (m_dpos < DT) m_dpos++;
         m_dir = (m_dpos == DT) ? 0 : 1;
      end else if (door_close || m_dir < 0) begin
         m_dpos--;
         m_dir = (m_dpos == 0) ? 0 : -1;
      end else if (m_dir > 0) begin
         m_dpos++;
         if (m_dpos == DT) m_dir = 0;
      end
   endtask

   task automatic tick();
      logic [3:0]  efs;
      logic [11:0] exp_v, act_v;
      model_step();
      @(posedge clk);
      #1;
      efs   = ((m_pos % T) == 0) ? (4'b0001 << (m_pos / T)) : 4'b0000;
      exp_v = {efs, 2'(m_pos / T), m_moving, 1'(m_dpos == 0), 1'(m_dpos == DT), m_fault};
      act_v = {floor_sensors, car_floor, moving, door_closed, door_fully_open, fault_flags};
      check("cycle_model", act_v, exp_v);
   endtask

   task automatic pulse_open();
      door_open = 1'b1; tick(); door_open = 1'b0;
   endtask

   task automatic pulse_close();
      door_close = 1'b1; tick(); door_close = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_fs", floor_sensors, 4'b0001);
      check("rst_floor", car_floor, 0);
      check("rst_closed", door_closed, 1);
      check("rst_faults", fault_flags, 0);

      // Travel up one floor, then to the top and into the end stop
      motor_up = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check("up_moving", moving, 1);
         if (i < 16) check("up_between_fs", floor_sensors, 4'b0000);
      end
      check("up_fs_f1", floor_sensors, 4'b0010);
      check("up_floor_f1", car_floor, 1);
      repeat (32) tick();
      check("top_fs", floor_sensors, 4'b1000);
      tick();
      check("overtravel_moving", moving, 0);
      check("overtravel_fault", fault_flags[2], 1);
      check("overtravel_floor", car_floor, 3);
      motor_up = 1'b0;
      motor_down = 1'b1;
      repeat (32) tick();
      motor_down = 1'b0;
      check("down_floor_f1", car_floor, 1);
      check("down_fs_f1", floor_sensors, 4'b0010);

      // Door open/close timing
      pulse_open();
      check("open_started", door_closed, 0);
      repeat (6) tick();
      check("open_not_yet", door_fully_open, 0);
      tick();
      check("open_full", door_fully_open, 1);
      pulse_close();
      check("close_started", door_fully_open, 0);
      repeat (6) tick();
      check("close_not_yet", door_closed, 0);
      tick();
      check("close_done", door_closed, 1);

      // Motor with door open, then both motors
      pulse_open();
      repeat (7) tick();
      motor_up = 1'b1;
      repeat (5) begin
         tick();
         check("door_interlock_moving", moving, 0);
      end
      check("door_interlock_floor", car_floor, 1);
      check("door_interlock_fs", floor_sensors, 4'b0010);
      check("door_interlock_fault", fault_flags[1], 1);
      motor_down = 1'b1;
      tick();
      check("both_motor_fault", fault_flags[0], 1);
      motor_up = 1'b0; motor_down = 1'b0;
      pulse_close();
      repeat (7) tick();
      check("reclosed", door_closed, 1);

      // Door open while between floors; reopen during closing
      motor_up = 1'b1;
      repeat (7) tick();
      motor_up = 1'b0;
      pulse_open();
      check("midtravel_door", door_closed, 1);
      check("midtravel_fault", fault_flags[3], 1);
      check("midtravel_fs", floor_sensors, 4'b0000);
      motor_up = 1'b1;
      repeat (9) tick();
      motor_up = 1'b0;
      check("f2_fs", floor_sensors, 4'b0100);
      pulse_open();
      repeat (7) tick();
      check("f2_open", door_fully_open, 1);
      pulse_close();
      repeat (3) tick();
      pulse_open();
      check("reopen_partial", door_fully_open, 0);
      repeat (2) tick();
      check("reopen_not_yet", door_fully_open, 0);
      tick();
      check("reopen_full", door_fully_open, 1);

      // open+close together while open: open wins, no fault
      door_open = 1'b1; door_close = 1'b1;
      tick();
      door_open = 1'b0; door_close = 1'b0;
      check("both_door_cmds", door_fully_open, 1);
      check("both_door_nofault", fault_flags, 4'b1111);
      pulse_close();
      repeat (7) tick();
      // Reverse while opening
      pulse_open();
      tick();
      pulse_close();
      tick();
      check("reverse_opening", door_closed, 1);

      // Reset mid-travel at sub=9 between floors 2 and 3
      motor_up = 1'b1;
      repeat (9) tick();
      check("sub9_fs", floor_sensors, 4'b0000);
      check("sub9_floor", car_floor, 2);
      motor_up = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_mid_fs", floor_sensors, 4'b0001);
      check("reset_mid_floor", car_floor, 0);
      check("reset_mid_faults", fault_flags, 0);
      check("reset_mid_moving", moving, 0);

      // Reset mid door opening
      pulse_open();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_door_closed", door_closed, 1);
      check("reset_door_open", door_fully_open, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
